// File: rtl/add_serial_n.sv
// add_serial_n: digit-serial adder, CHUNK bits per clock, WIDTH-bit result.
// Optional ADD_SERIAL_OVF_EN macro enables the registered two's-complement overflow flag.
module add_serial_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             carry_q;
    logic [WIDTH-1:0] part_q;

    logic             accept;
    logic             last;
    logic [CHUNK:0]   chunk_full;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_c;
    logic [WIDTH-1:0] part_next;

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == RUN) && (cnt_q == CW'(N - 1));

    // One chunk of the addition: low operand bits plus the linking carry.
    assign chunk_full = {1'b0, op_a_q[CHUNK-1:0]}
                      + {1'b0, op_b_q[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_q};
    assign chunk_sum  = chunk_full[CHUNK-1:0];
    assign chunk_c    = chunk_full[CHUNK];

    // New chunk enters at the top so the last chunk lands in the MSBs.
    generate
        if (N == 1) begin : g_single
            assign part_next = chunk_sum;
        end else begin : g_multi
            assign part_next = {chunk_sum, part_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, chunk shifting and carry linking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            op_a_q  <= a;
            op_b_q  <= b;
            carry_q <= c_in;
            part_q  <= '0;
        end else if (state_q == RUN) begin
            cnt_q   <= cnt_q + 1'b1;
            op_a_q  <= op_a_q >> CHUNK;
            op_b_q  <= op_b_q >> CHUNK;
            carry_q <= chunk_c;
            part_q  <= part_next;
        end
    end

    // Visible result only changes on the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else if (last) begin
            sum   <= part_next;
            c_out <= chunk_c;
        end
    end

`ifdef ADD_SERIAL_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into the MSB recovered from the top bit's operands and sum.
    assign msb_cin = op_a_q[CHUNK-1] ^ op_b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];

    // Overflow registered alongside sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= msb_cin ^ chunk_c;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_add_serial_n.sv
// tb_add_serial_n: scoreboard bench for add_serial_n.
// Expected results come from plain wide arithmetic; a monitor checks every cycle.
module tb_add_serial_n;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    add_serial_n #(.WIDTH(W), .CHUNK(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           at_cyc;
    } exp_t;

    exp_t         q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           free_at = 0;
    logic [W-1:0] last_s = '0;
    logic         last_co = 1'b0;
    logic         last_ov = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av,
                                   input logic [W-1:0] bv,
                                   input logic ci, input int at);
        exp_t e;
        logic [W:0] full;
        full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        e.s  = full[W-1:0];
        e.co = full[W];
`ifdef ADD_SERIAL_OVF_EN
        e.ov = (av[W-1] == bv[W-1]) && (e.s[W-1] != av[W-1]);
`else
        e.ov = 1'b0;
`endif
        e.at_cyc = at;
        return e;
    endfunction

    task automatic drive(input logic s, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ci);
        int e;
        @(negedge clk);
        start = s;
        a     = av;
        b     = bv;
        c_in  = ci;
        e     = cyc + 1;
        if (s && !rst && e >= free_at) begin
            q.push_back(model(av, bv, ci, e + N));
            free_at = e + N + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, $urandom, $urandom, 1'($urandom));
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        q.delete();
        free_at = 0;
        last_s  = '0;
        last_co = 1'b0;
        last_ov = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: checks handshake timing, held result and completions.
    always @(posedge clk) begin
        logic exp_done;
        logic exp_busy;
        #1;
        if (rst) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
        end else begin
            exp_done = (q.size() > 0) && (q[0].at_cyc == cyc);
            exp_busy = (q.size() > 0) && (cyc >= q[0].at_cyc - N)
                       && (cyc < q[0].at_cyc);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_done) begin
                last_s  = q[0].s;
                last_co = q[0].co;
                last_ov = q[0].ov;
                void'(q.pop_front());
            end
            chk("sum", 32'(sum), 32'(last_s));
            chk("c_out", 32'(c_out), 32'(last_co));
            chk("overflow", 32'(overflow), 32'(last_ov));
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        #1;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_sum", 32'(sum), 32'd0);
        chk("init_cout", 32'(c_out), 32'd0);
        chk("init_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
        idle(N + 3);
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        idle(N + 3);
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        idle(N + 3);
        drive(1'b1, 16'h8000, 16'h8000, 1'b0);
        idle(N + 3);

        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        idle(N + 3);

        drive(1'b1, 16'h1234, 16'h1111, 1'b0);
        idle(2);
        do_reset(2);
        idle(2);
        drive(1'b1, 16'h1234, 16'h1111, 1'b0);
        idle(N + 3);
        chk("post_rst_sum", 32'(sum), 32'h2345);

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 2) == 0), 16'($urandom),
                  16'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            idle(1);
        end
        idle(2);
        chk("drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
